word_packer: RTL and testbench

Downstream consumer of the single-entry handoff buffer. It drains narrow IN_W-bit entries whenever the buffer reports busy, packs PACK consecutive entries into one OUT_W-bit word, and presents that word on a valid/ready output stream. It lets the narrow buffer feed wider datapaths (bus writers, CRC units) without dropping entries.

---
 rtl/word_packer_pkg.sv | 20 ++
 rtl/packer_out_slot.sv | 44 ++++
 rtl/word_packer.sv | 121 ++++++++++++
 tb/tb_word_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_packer_pkg.sv
// Shared definitions for the word_packer slice: width helper, pack limit, FSM states.
package word_packer_pkg;

   localparam int MAX_PACK = 16;

   typedef enum logic {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_e;

   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/packer_out_slot.sv
// Single-entry valid/ready output register: load takes priority, accept empties the slot,
// otherwise data and valid hold. The caller only loads when the slot is free or being accepted.
module packer_out_slot
   import word_packer_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/word_packer.sv
// Drains IN_W-bit buffer entries and packs PACK of them (first entry in the low lanes) into one
// OUT_W-bit valid/ready word. Optional partial-word flush is enabled by PACKER_FLUSH_EN.
module word_packer
   import word_packer_pkg::*;
#(
   parameter int IN_W  = 2,
   parameter int PACK  = 4,
   parameter int OUT_W = IN_W * PACK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             src_busy,
   output logic             src_rd_e,
   input  logic [IN_W-1:0]  src_rd_data,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
`ifdef PACKER_FLUSH_EN
   input  logic                        flush,
   output logic [clog2_f(PACK+1)-1:0]  out_lanes,
`endif
   input  logic             out_ready
);

   localparam int CNT_W = clog2_f(PACK);
   localparam int ACC_W = (PACK - 1) * IN_W;
`ifdef PACKER_FLUSH_EN
   localparam int LN_W   = clog2_f(PACK + 1);
   localparam int SLOT_W = OUT_W + LN_W;
`else
   localparam int SLOT_W = OUT_W;
`endif

   // STALL is registered as "last lane pending and slot occupied"; reads are
   // blocked only while out_ready is also low, so a same-cycle accept frees the path.
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d, acc_m;
   logic             stall, take, full, load, valid_next;
   logic [OUT_W-1:0] load_word;
   logic [SLOT_W-1:0] slot_in, slot_out;

`ifdef PACKER_FLUSH_EN
   logic            pend_q, pend_d;
   logic            slot_free, flush_req, has_lanes;
   logic [LN_W-1:0] lanes;
`endif

   always_comb begin
      stall     = (state_q == STALL) && !out_ready;
      take      = src_busy && !stall && !rst;
      full      = take && (cnt_q == CNT_W'(PACK - 1));
      acc_m     = acc_q;
      for (int i = 0; i < PACK - 1; i++) begin
         if (take && (cnt_q == CNT_W'(i))) acc_m[i*IN_W +: IN_W] = src_rd_data;
      end
      load      = full;
      load_word = {src_rd_data, acc_q};
`ifdef PACKER_FLUSH_EN
      slot_free = !out_valid || out_ready;
      flush_req = flush || pend_q;
      has_lanes = (cnt_q != '0) || take;
      lanes     = full ? LN_W'(PACK) : (LN_W'(cnt_q) + LN_W'(take));
      pend_d    = 1'b0;
      // A flush that cannot load yet is remembered; further reads keep filling lanes meanwhile.
      if (!full && flush_req && has_lanes) begin
         if (slot_free) begin
            load      = 1'b1;
            load_word = {{IN_W{1'b0}}, acc_m};
         end else begin
            pend_d = 1'b1;
         end
      end
      slot_in = {lanes, load_word};
`else
      slot_in = load_word;
`endif
      cnt_d = cnt_q + CNT_W'(take);
      acc_d = acc_m;
      if (load) begin
         cnt_d = '0;
         acc_d = '0;
      end
      valid_next = load || (out_valid && !out_ready);
      state_d    = ((cnt_d == CNT_W'(PACK - 1)) && valid_next) ? STALL : FILL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         acc_q   <= '0;
`ifdef PACKER_FLUSH_EN
         pend_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
`ifdef PACKER_FLUSH_EN
         pend_q  <= pend_d;
`endif
      end
   end

   packer_out_slot #(.W(SLOT_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (slot_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (slot_out)
   );

   assign src_rd_e = take;
   assign out_data = slot_out[OUT_W-1:0];
`ifdef PACKER_FLUSH_EN
   assign out_lanes = slot_out[OUT_W +: LN_W];
`endif

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer (IN_W=2, PACK=4); flush scenario built when PACKER_FLUSH_EN is set.
module tb_word_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       src_busy;
   logic       src_rd_e;
   logic [1:0] src_rd_data;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
`ifdef PACKER_FLUSH_EN
   logic       flush;
   logic [2:0] out_lanes;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   word_packer #(.IN_W(2), .PACK(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .src_busy    (src_busy),
      .src_rd_e    (src_rd_e),
      .src_rd_data (src_rd_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
`ifdef PACKER_FLUSH_EN
      .flush       (flush),
      .out_lanes   (out_lanes),
`endif
      .out_ready   (out_ready)
   );

   // ---------------- clock / reset / drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic b, input logic [1:0] d, input logic r);
      src_busy    = b;
      src_rd_data = d;
      out_ready   = r;
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      src_busy    = 1'b0;
      src_rd_data = 2'd0;
      out_ready   = 1'b0;
`ifdef PACKER_FLUSH_EN
      flush       = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      drive(1'b1, 2'd2, 1'b1);
      n_checks++;
      if (src_rd_e !== 1'b0) begin n_fail++; $display("FAIL reset_rd_e got=%b exp=0", src_rd_e); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_checks++;
      if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
      rst = 1'b0;
      drive(1'b0, 2'd0, 1'b0);
      n_checks++;
      if (src_rd_e !== 1'b0) begin n_fail++; $display("FAIL idle_rd_e got=%b exp=0", src_rd_e); end
   endtask

   task automatic test_single_word();
      logic [1:0] ent[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ent[i], 1'b1);
         n_checks++;
         if (src_rd_e !== 1'b1) begin n_fail++; $display("FAIL single_rd_e[%0d] got=%b exp=1", i, src_rd_e); end
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid[%0d] got=%b exp=0", i, out_valid); end
         tick();
      end
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      n_checks++;
      if (out_data !== 8'h39) begin n_fail++; $display("FAIL single_data got=%h exp=39", out_data); end
      drive(1'b0, 2'd0, 1'b1);
      n_checks++;
      if (src_rd_e !== 1'b0) begin n_fail++; $display("FAIL single_no_busy_rd_e got=%b exp=0", src_rd_e); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop_valid got=%b exp=0", out_valid); end
      n_checks++;
      if (out_data !== 8'h39) begin n_fail++; $display("FAIL single_hold_data got=%h exp=39", out_data); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ent[8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
      logic [7:0] exp_q[$];
      logic [7:0] exp_w;
      do_reset();
      exp_q.push_back(8'h39);
      exp_q.push_back(8'h6C);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, ent[i], 1'b1);
         n_checks++;
         if (src_rd_e !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_e[%0d] got=%b exp=1", i, src_rd_e); end
         tick();
         if ((i % 4) == 3) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
            n_checks++;
            if (out_data !== exp_w) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, exp_w); end
         end else begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid[%0d] got=%b exp=0", i, out_valid); end
         end
      end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_stall();
      logic [1:0] ent[7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, ent[i], 1'b0);
         n_checks++;
         if (src_rd_e !== 1'b1) begin n_fail++; $display("FAIL stall_fill_rd_e[%0d] got=%b exp=1", i, src_rd_e); end
         tick();
         if (i >= 3) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h39) begin
               n_fail++;
               $display("FAIL stall_hold[%0d] got valid=%b data=%h exp valid=1 data=39", i, out_valid, out_data);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'd1, 1'b0);
         n_checks++;
         if (src_rd_e !== 1'b0) begin n_fail++; $display("FAIL stall_rd_e[%0d] got=%b exp=0", i, src_rd_e); end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h39) begin
            n_fail++;
            $display("FAIL stall_stable[%0d] got valid=%b data=%h exp valid=1 data=39", i, out_valid, out_data);
         end
      end
      drive(1'b1, 2'd1, 1'b1);
      n_checks++;
      if (src_rd_e !== 1'b1) begin n_fail++; $display("FAIL release_rd_e got=%b exp=1", src_rd_e); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid got=%b exp=1", out_valid); end
      n_checks++;
      if (out_data !== 8'h6C) begin n_fail++; $display("FAIL release_data got=%h exp=6c", out_data); end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_busy_toggle();
      logic       bv[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [1:0] dv[7] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(bv[i], dv[i], 1'b1);
         n_checks++;
         if (src_rd_e !== bv[i]) begin n_fail++; $display("FAIL toggle_rd_e[%0d] got=%b exp=%b", i, src_rd_e, bv[i]); end
         tick();
         if (i < 6) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL toggle_early_valid[%0d] got=%b exp=0", i, out_valid); end
         end
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h39) begin
         n_fail++;
         $display("FAIL toggle_word got valid=%b data=%h exp valid=1 data=39", out_valid, out_data);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] ent[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      drive(1'b1, 2'd3, 1'b1);
      tick();
      drive(1'b1, 2'd3, 1'b1);
      tick();
      rst = 1'b1;
      drive(1'b1, 2'd3, 1'b1);
      n_checks++;
      if (src_rd_e !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd_e got=%b exp=0", src_rd_e); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ent[i], 1'b1);
         tick();
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h39) begin
         n_fail++;
         $display("FAIL mid_rst_word got valid=%b data=%h exp valid=1 data=39", out_valid, out_data);
      end
   endtask

`ifdef PACKER_FLUSH_EN
   task automatic test_flush();
      logic [1:0] ent[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      drive(1'b1, 2'd2, 1'b1);
      tick();
      drive(1'b1, 2'd1, 1'b1);
      tick();
      flush = 1'b1;
      drive(1'b0, 2'd0, 1'b1);
      tick();
      flush = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h06) begin
         n_fail++;
         $display("FAIL flush_word got valid=%b data=%h exp valid=1 data=06", out_valid, out_data);
      end
      n_checks++;
      if (out_lanes !== 3'd2) begin n_fail++; $display("FAIL flush_lanes got=%0d exp=2", out_lanes); end
      flush = 1'b1;
      drive(1'b0, 2'd0, 1'b1);
      tick();
      flush = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got=%b exp=0", out_valid); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ent[i], 1'b1);
         tick();
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h39 || out_lanes !== 3'd4) begin
         n_fail++;
         $display("FAIL flush_full_word got valid=%b data=%h lanes=%0d exp valid=1 data=39 lanes=4",
                  out_valid, out_data, out_lanes);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_busy_toggle();
      test_reset_mid();
`ifdef PACKER_FLUSH_EN
      test_flush();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
